// File: rtl/rob_issue_fifo.sv
// Purpose: in-order decoupling buffer between the ROB issue port and register-read/execute.
// Latency: 1 cycle (enqueued at edge N, visible on deq_data_out after edge N); no empty bypass.
// Backpressure: enq_ready_out = count < DEPTH from registered state only; deq side is valid/ready.
//
// Ports:
//   clk_in, rst_in          clock (rising edge), async active-high reset
//   flush_in                sync flush: drops all entries, blocks any fire that cycle
//   enq_valid_in/_ready_out/enq_data_in    ROB-side handshake and packet
//   deq_valid_out/deq_ready_in/deq_data_out execute-side handshake and head packet
//   count_out               occupancy 0..DEPTH
//   almost_full_out         count_out >= AFULL_THRESH

package rob_pkg;

  typedef struct packed {
    logic        valid;
    logic [15:0] uop;
    logic [5:0]  ptr;
    logic [6:0]  prd;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
  } rob_issue;

endpackage

module rob_issue_fifo #(
  parameter int unsigned DEPTH        = 8,        // power of 2, >= 2
  parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     enq_valid_in,
  input  rob_pkg::rob_issue        enq_data_in,
  output logic                     enq_ready_out,
  output logic                     deq_valid_out,
  output rob_pkg::rob_issue        deq_data_out,
  input  logic                     deq_ready_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     almost_full_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rob_pkg::rob_issue mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic enq_fire;
  logic deq_fire;

  // Both ready/valid derive only from registered count, so there is no
  // combinational path from deq_ready_in to enq_ready_out.
  assign enq_ready_out   = (count_q < CW'(DEPTH));
  assign deq_valid_out   = (count_q != '0);
  assign almost_full_out = (count_q >= CW'(AFULL_THRESH));
  assign count_out       = count_q;
  assign deq_data_out    = mem_q[rd_ptr_q];

  assign enq_fire = enq_valid_in & enq_ready_out & ~flush_in;
  assign deq_fire = deq_valid_out & deq_ready_in & ~flush_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of 2, so pointer increments wrap naturally.
      if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head output reads as zero straight
  // out of reset (rd_ptr is 0 and entry 0 is zero).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_fire) begin
      mem_q[wr_ptr_q] <= enq_data_in;
    end
  end

  a_count_bound : assert property (@(posedge clk_in) disable iff (rst_in)
    count_q <= CW'(DEPTH));

  a_no_enq_when_full : assert property (@(posedge clk_in) disable iff (rst_in)
    !(enq_fire && (count_q == CW'(DEPTH))));

  a_head_stable : assert property (@(posedge clk_in) disable iff (rst_in)
    (deq_valid_out && !deq_ready_in && !flush_in) |=> $stable(deq_data_out));

endmodule

// File: tb/tb_rob_issue_fifo.sv
// Purpose: directed self-checking bench for rob_issue_fifo.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked there too.
// Backpressure: exercises full, toggling deq_ready, flush and async reset.

module tb_rob_issue_fifo;

  logic              clk_in;
  logic              rst_in;
  logic              flush_in;
  logic              enq_valid_in;
  rob_pkg::rob_issue enq_data_in;
  logic              enq_ready_out;
  logic              deq_valid_out;
  rob_pkg::rob_issue deq_data_out;
  logic              deq_ready_in;
  logic [3:0]        count_out;
  logic              almost_full_out;

  int vectors;
  int miscompares;

  rob_issue_fifo #(.DEPTH(8)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .enq_valid_in    (enq_valid_in),
    .enq_data_in     (enq_data_in),
    .enq_ready_out   (enq_ready_out),
    .deq_valid_out   (deq_valid_out),
    .deq_data_out    (deq_data_out),
    .deq_ready_in    (deq_ready_in),
    .count_out       (count_out),
    .almost_full_out (almost_full_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet whose fields are all derived from the ROB pointer value.
  function automatic rob_pkg::rob_issue mk(input int p);
    rob_pkg::rob_issue r;
    r.valid = p[0];
    r.uop   = 16'hA500 | 16'(p);
    r.ptr   = 6'(p);
    r.prd   = 7'(p + 1);
    r.prs1  = 7'(p + 2);
    r.prs2  = 7'(p + 3);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill(input int first, input int n);
    enq_valid_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      enq_data_in = mk(first + i);
      cyc();
    end
    enq_valid_in = 1'b0;
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc_n;
    logic ef;
    logic df;

    vectors      = 0;
    miscompares  = 0;
    rst_in       = 1'b1;
    flush_in     = 1'b0;
    enq_valid_in = 1'b0;
    enq_data_in  = '0;
    deq_ready_in = 1'b0;

    // Reset state
    cyc();
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid_out), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready_out), 64'd1);
    chk("rst_deq_data", 64'(deq_data_out), 64'd0);
    chk("rst_afull", 64'(almost_full_out), 64'd0);
    rst_in = 1'b0;
    cyc();

    // 1: three packets held at head, then drained in order
    fill(5, 3);
    chk("t1_count", 64'(count_out), 64'd3);
    chk("t1_valid", 64'(deq_valid_out), 64'd1);
    chk("t1_head", 64'(deq_data_out), 64'(mk(5)));
    cyc();
    cyc();
    chk("t1_head_held", 64'(deq_data_out), 64'(mk(5)));
    deq_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_order", 64'(deq_data_out), 64'(mk(5 + i)));
      cyc();
    end
    deq_ready_in = 1'b0;
    chk("t1_count_end", 64'(count_out), 64'd0);
    chk("t1_valid_end", 64'(deq_valid_out), 64'd0);

    // 2: fill to full, hold off 9th, one deq opens slot next cycle
    enq_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enq_data_in = mk(i);
      cyc();
      chk("t2_count", 64'(count_out), 64'(i + 1));
      chk("t2_afull", 64'(almost_full_out), ((i + 1) >= 6) ? 64'd1 : 64'd0);
    end
    chk("t2_full_ready", 64'(enq_ready_out), 64'd0);
    enq_data_in = mk(8);
    cyc();
    cyc();
    chk("t2_held_off", 64'(count_out), 64'd8);
    deq_ready_in = 1'b1;
    cyc();
    deq_ready_in = 1'b0;
    chk("t2_after_deq_count", 64'(count_out), 64'd7);
    chk("t2_after_deq_ready", 64'(enq_ready_out), 64'd1);
    chk("t2_after_deq_head", 64'(deq_data_out), 64'(mk(1)));
    cyc();
    enq_valid_in = 1'b0;
    chk("t2_ninth_in", 64'(count_out), 64'd8);
    deq_ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", 64'(deq_data_out), 64'(mk(i)));
      cyc();
    end
    deq_ready_in = 1'b0;
    chk("t2_empty", 64'(count_out), 64'd0);

    // 3: stream 20 packets with deq_ready toggling 1,0,1,0...
    sent  = 0;
    rcv   = 0;
    cyc_n = 0;
    while (rcv < 20 && cyc_n < 200) begin
      enq_valid_in = (sent < 20);
      enq_data_in  = mk(10 + sent);
      deq_ready_in = (cyc_n % 2 == 0);
      ef = enq_valid_in && enq_ready_out;
      df = deq_valid_out && deq_ready_in;
      if (df) chk("t3_order", 64'(deq_data_out), 64'(mk(10 + rcv)));
      cyc();
      cyc_n++;
      if (ef) sent++;
      if (df) rcv++;
      chk("t3_count", 64'(count_out), 64'(sent - rcv));
      chk("t3_max", 64'(count_out <= 4'd8), 64'd1);
    end
    enq_valid_in = 1'b0;
    deq_ready_in = 1'b0;
    chk("t3_all_received", 64'(rcv), 64'd20);

    // 4: simultaneous enq+deq at count=4
    fill(30, 4);
    chk("t4_count_start", 64'(count_out), 64'd4);
    enq_valid_in = 1'b1;
    deq_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_data_in = mk(34 + i);
      chk("t4_order", 64'(deq_data_out), 64'(mk(30 + i)));
      cyc();
      chk("t4_count", 64'(count_out), 64'd4);
    end
    enq_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", 64'(deq_data_out), 64'(mk(40 + i)));
      cyc();
    end
    deq_ready_in = 1'b0;
    chk("t4_empty", 64'(count_out), 64'd0);

    // 5: flush at count=5 with enq and deq both offered
    fill(50, 5);
    chk("t5_count_pre", 64'(count_out), 64'd5);
    flush_in     = 1'b1;
    enq_valid_in = 1'b1;
    enq_data_in  = mk(60);
    deq_ready_in = 1'b1;
    cyc();
    flush_in     = 1'b0;
    enq_valid_in = 1'b0;
    deq_ready_in = 1'b0;
    chk("t5_count", 64'(count_out), 64'd0);
    chk("t5_valid", 64'(deq_valid_out), 64'd0);
    chk("t5_ready", 64'(enq_ready_out), 64'd1);
    cyc();
    chk("t5_count_later", 64'(count_out), 64'd0);
    fill(42, 1);
    chk("t5_ptr42", 64'(deq_data_out.ptr), 64'd42);
    chk("t5_pkt42", 64'(deq_data_out), 64'(mk(42)));
    chk("t5_count_one", 64'(count_out), 64'd1);
    deq_ready_in = 1'b1;
    cyc();
    deq_ready_in = 1'b0;
    chk("t5_count_final", 64'(count_out), 64'd0);

    // 6: async reset mid-cycle at count=6
    fill(1, 6);
    chk("t6_count_pre", 64'(count_out), 64'd6);
    chk("t6_afull_pre", 64'(almost_full_out), 64'd1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t6_count", 64'(count_out), 64'd0);
    chk("t6_valid", 64'(deq_valid_out), 64'd0);
    chk("t6_data", 64'(deq_data_out), 64'd0);
    chk("t6_ready", 64'(enq_ready_out), 64'd1);
    chk("t6_afull", 64'(almost_full_out), 64'd0);
    cyc();
    rst_in = 1'b0;
    cyc();
    chk("t6_count_after", 64'(count_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
